// File: rtl/dff8_load_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dff8_load_seq: serial loader for an 8-bit individually clocked bank  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+

module dff8_load_seq #(
  parameter int SETUP_CYC = 1,
  parameter int HIGH_CYC  = 1
) (
  input  logic       ff_clock,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  input  logic [7:0] wr_mask,
  output logic       data_in,
  output logic [7:0] strobe,
  output logic       busy,
  output logic       done,
  output logic [7:0] mirror
);

  localparam logic [2:0] C_IDLE  = 3'd0;
  localparam logic [2:0] C_SCAN  = 3'd1;
  localparam logic [2:0] C_SETUP = 3'd2;
  localparam logic [2:0] C_PULSE = 3'd3;
  localparam logic [2:0] C_HOLD  = 3'd4;
  localparam logic [2:0] C_DONE  = 3'd5;

  localparam logic [3:0] C_SETUP_LOAD = 4'(SETUP_CYC - 1);
  localparam logic [3:0] C_HIGH_LOAD  = 4'(HIGH_CYC - 1);

  logic [2:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] phase_q, phase_d;
  logic [7:0] data_q, data_d;
  logic [7:0] mask_q, mask_d;
  logic       data_in_q, data_in_d;
  logic [7:0] strobe_q, strobe_d;
  logic       done_q, done_d;
  logic [7:0] mirror_q, mirror_d;

  always_ff @(posedge ff_clock or posedge rst) begin
    if (rst) begin
      state_q   <= C_IDLE;
      idx_q     <= 3'd0;
      phase_q   <= 4'd0;
      data_q    <= 8'h00;
      mask_q    <= 8'h00;
      data_in_q <= 1'b0;
      strobe_q  <= 8'h00;
      done_q    <= 1'b0;
      mirror_q  <= 8'h00;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      phase_q   <= phase_d;
      data_q    <= data_d;
      mask_q    <= mask_d;
      data_in_q <= data_in_d;
      strobe_q  <= strobe_d;
      done_q    <= done_d;
      mirror_q  <= mirror_d;
    end
  end

  always_comb begin : next_state
    state_d = state_q;
    idx_d   = idx_q;
    phase_d = phase_q;
    data_d  = data_q;
    mask_d  = mask_q;
    case (state_q)
      C_IDLE: begin
        if (wr_valid) begin
          data_d  = wr_data;
          mask_d  = wr_mask;
          idx_d   = 3'd0;
          state_d = C_SCAN;
        end
      end
      C_SCAN: begin
        if (mask_q[idx_q]) begin
          phase_d = C_SETUP_LOAD;
          state_d = C_SETUP;
        end else if (idx_q == 3'd7) begin
          state_d = C_DONE;
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      C_SETUP: begin
        if (phase_q == 4'd0) begin
          phase_d = C_HIGH_LOAD;
          state_d = C_PULSE;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      C_PULSE: begin
        if (phase_q == 4'd0) begin
          state_d = C_HOLD;
        end else begin
          phase_d = phase_q - 4'd1;
        end
      end
      C_HOLD: begin
        if (idx_q == 3'd7) begin
          state_d = C_DONE;
        end else begin
          idx_d   = idx_q + 3'd1;
          state_d = C_SCAN;
        end
      end
      C_DONE:  state_d = C_IDLE;
      default: state_d = C_IDLE;
    endcase
  end

  // Registered outputs are computed from the next state so every strobe
  // edge comes straight off a flop and lines up with its state.
  always_comb begin : outputs_next
    data_in_d = data_in_q;
    mirror_d  = mirror_q;
    strobe_d  = 8'h00;
    done_d    = (state_d == C_DONE);
    if (state_d == C_PULSE) begin
      strobe_d = 8'h80 >> idx_d;
    end
    if ((state_q == C_SCAN) && (state_d == C_SETUP)) begin
      data_in_d = data_q[idx_q];
    end
    if ((state_q == C_SETUP) && (state_d == C_PULSE)) begin
      mirror_d[idx_q] = data_q[idx_q];
    end
  end

  assign wr_ready = (state_q == C_IDLE);
  assign busy     = (state_q != C_IDLE);
  assign data_in  = data_in_q;
  assign strobe   = strobe_q;
  assign done     = done_q;
  assign mirror   = mirror_q;

endmodule

`default_nettype wire

// File: tb/tb_dff8_load_seq.sv
`default_nettype none
// Scoreboard bench for dff8_load_seq: random writes against a mask/popcount
// model, a behavioural flop bank, and a second instance with stretched timing.

module tb_dff8_load_seq;

  localparam int S = 1;
  localparam int H = 1;

  typedef struct {
    logic [7:0] data;
    logic [7:0] mask;
    logic [7:0] exp_mirror;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_valid = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] wr_mask = 8'h00;
  logic       wr_ready, data_in, busy, done;
  logic [7:0] strobe, mirror;

  logic       p_valid = 1'b0;
  logic [7:0] p_data = 8'h00;
  logic [7:0] p_mask = 8'h00;
  logic       p_ready, p_data_in, p_busy, p_done;
  logic [7:0] p_strobe, p_mirror;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int done_cyc = -10;
  exp_t sb_q[$];
  logic [7:0] model_mirror = 8'h00;
  logic [7:0] bank;

  dff8_load_seq dut (
    .ff_clock(clk), .rst(rst), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_data(wr_data), .wr_mask(wr_mask), .data_in(data_in), .strobe(strobe),
    .busy(busy), .done(done), .mirror(mirror)
  );

  dff8_load_seq #(.SETUP_CYC(3), .HIGH_CYC(2)) dut_p (
    .ff_clock(clk), .rst(rst), .wr_valid(p_valid), .wr_ready(p_ready),
    .wr_data(p_data), .wr_mask(p_mask), .data_in(p_data_in), .strobe(p_strobe),
    .busy(p_busy), .done(p_done), .mirror(p_mirror)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Flop bank as the real hardware sees it: bit k clocked by strobe[7-k].
  for (genvar k = 0; k < 8; k++) begin : g_bank
    logic q;
    always @(posedge strobe[7-k] or posedge rst) begin
      if (rst) q <= 1'b0;
      else     q <= data_in;
    end
    assign bank[k] = q;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Monitor: per-cycle strobe checks against the front of the scoreboard,
  // full transaction check when done pulses.
  initial begin
    int busy_cnt, rises, hi_cnt, stable_cnt, last_bit, b;
    logic [7:0] prev_strobe, rise_v;
    logic prev_din;
    exp_t e;
    busy_cnt = 0; rises = 0; hi_cnt = 0; stable_cnt = 0; last_bit = -1;
    prev_strobe = 8'h00; prev_din = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb_q.delete();
        busy_cnt = 0; rises = 0; hi_cnt = 0; stable_cnt = 0; last_bit = -1;
        prev_strobe = 8'h00; prev_din = 1'b0;
      end else begin
        chk("strobe_onehot0", {31'd0, $onehot0(strobe)}, 1);
        if (busy) busy_cnt++;
        if (data_in != prev_din) stable_cnt = 1;
        else stable_cnt++;
        if (strobe != 8'h00) hi_cnt++;
        rise_v = strobe & ~prev_strobe;
        if (rise_v != 8'h00) begin
          if (sb_q.size() == 0) begin
            chk("strobe_while_idle", strobe, 0);
          end else begin
            e = sb_q[0];
            b = last_bit + 1;
            while (b < 8 && !e.mask[b]) b++;
            if (b >= 8) begin
              chk("extra_strobe", strobe, 0);
            end else begin
              chk("strobe_bit", strobe, 8'h80 >> b);
              chk("data_at_rise", data_in, e.data[b]);
              chk("mirror_at_rise", mirror[b], e.data[b]);
              chk("setup_stable", stable_cnt >= S + 1, 1);
              last_bit = b;
              rises++;
            end
          end
        end
        if (strobe == 8'h00 && prev_strobe != 8'h00) begin
          chk("strobe_high_cycles", hi_cnt, H);
          hi_cnt = 0;
        end
        if (done) begin
          if (sb_q.size() == 0) begin
            chk("done_unexpected", 1, 0);
          end else begin
            e = sb_q.pop_front();
            chk("busy_cycles", busy_cnt, 8 + $countones(e.mask) * (S + H + 1) + 1);
            chk("mirror_done", mirror, e.exp_mirror);
            chk("bank_done", bank, e.exp_mirror);
            chk("strobe_count", rises, $countones(e.mask));
          end
          busy_cnt = 0; rises = 0; last_bit = -1;
          done_cyc = cyc;
        end
        prev_strobe = strobe;
        prev_din = data_in;
      end
    end
  end

  task automatic do_write(input logic [7:0] d, input logic [7:0] m);
    int waited;
    exp_t e;
    @(negedge clk);
    wr_valid = 1'b1; wr_data = d; wr_mask = m;
    waited = 0;
    while (!wr_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!wr_ready) begin
      chk("handshake_timeout", 0, 1);
    end else begin
      if (waited > 0) chk("b2b_accept_after_done", cyc, done_cyc + 1);
      model_mirror = (model_mirror & ~m) | (d & m);
      e.data = d; e.mask = m; e.exp_mirror = model_mirror;
      sb_q.push_back(e);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0; wr_data = 8'($urandom); wr_mask = 8'($urandom);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || sb_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic param_test();
    int chg, rise, hi, bcnt, n;
    logic pd;
    logic [7:0] other;
    @(negedge clk);
    p_valid = 1'b1; p_data = 8'h01; p_mask = 8'h01;
    @(posedge clk); #1;
    p_valid = 1'b0;
    chg = -1; rise = -1; hi = 0; bcnt = 0; other = 8'h00;
    pd = p_data_in;
    for (n = 0; n < 100; n++) begin
      @(negedge clk);
      if (p_busy) bcnt++;
      if (p_data_in != pd && chg < 0) chg = n;
      pd = p_data_in;
      other = other | (p_strobe & 8'h7F);
      if (p_strobe[7]) begin
        if (rise < 0) rise = n;
        hi++;
      end
      if (p_done) break;
    end
    chk("p_done_seen", p_done, 1);
    chk("p_setup_cycles", rise - chg, 3);
    chk("p_high_cycles", hi, 2);
    chk("p_busy_cycles", bcnt, 15);
    chk("p_other_strobes", other, 0);
    chk("p_mirror", p_mirror, 8'h01);
  endtask

  initial begin
    int w;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", strobe, 0);
    chk("rst_data_in", data_in, 0);
    chk("rst_done", done, 0);
    chk("rst_mirror", mirror, 0);

    do_write(8'hA5, 8'hFF);
    wait_idle();
    do_write(8'hFF, 8'hFF);
    wait_idle();
    do_write(8'h00, 8'h12);
    wait_idle();
    chk("partial_mirror", mirror, 8'hED);
    do_write(8'($urandom), 8'h00);
    wait_idle();
    chk("empty_mask_mirror", mirror, 8'hED);

    do_write(8'h3C, 8'h0F);
    do_write(8'hC3, 8'hF0);
    wait_idle();

    for (int i = 0; i < 16; i++) begin
      logic [7:0] m;
      case ($urandom_range(0, 3))
        0: m = 8'h00;
        1: m = 8'hFF;
        default: m = 8'($urandom);
      endcase
      do_write(8'($urandom), m);
      if ($urandom_range(0, 1) == 0) begin
        wait_idle();
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
    end
    wait_idle();

    do_write(8'($urandom), 8'hFF);
    w = 0;
    do begin
      @(posedge clk); #1;
      w++;
    end while (!strobe[4] && w < 100);
    chk("reach_pulse_bit3", strobe[4], 1);
    #2 rst = 1'b1;
    #1;
    chk("arst_strobe", strobe, 0);
    chk("arst_data_in", data_in, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_mirror", mirror, 0);
    chk("arst_bank", bank, 0);
    model_mirror = 8'h00;
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_ready", wr_ready, 1);
    do_write(8'h5A, 8'h99);
    wait_idle();
    chk("post_rst_mirror", mirror, 8'h18);

    param_test();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/dff8_load_seq.md
# dff8_load_seq

Sequencer that loads a byte into the 8-bit individually clocked flop bank, one bit at a time, over its shared serial data line and eight per-bit clock strobes. Accepts write requests with a per-bit mask through a valid/ready handshake. Generates glitch-free, registered strobe pulses with programmable setup and high time. Keeps a shadow copy of the bank contents. Sits between the register-write logic and the flop bank; the bank shares `rst` with this block.

## Interface

Parameters:
- `SETUP_CYC`, default 1: cycles `data_in` is stable before a strobe rises. Legal range 1..15.
- `HIGH_CYC`, default 1: cycles a strobe stays high. Legal range 1..15.

Ports:
- `ff_clock` input 1: block clock. All state updates on its rising edge.
- `rst` input 1: reset, asynchronous, active-high.
- `wr_valid` input 1: write request.
- `wr_ready` output 1: block idle and able to accept a request.
- `wr_data` input 8: byte to load. Bit i is the value for bank bit i.
- `wr_mask` input 8: bank bit i is updated only if `wr_mask[i]` = 1.
- `data_in` output 1: serial data to the bank.
- `strobe` output 8: per-bit clocks to the bank. `strobe[7-i]` captures bank bit i.
- `busy` output 1: sequence in progress.
- `done` output 1: one-cycle pulse when a sequence completes.
- `mirror` output 8: shadow of bank contents.

## Operation

- States: IDLE, SCAN, SETUP, PULSE, HOLD, DONE.
- Internal registers:
  - 3-bit bit index `idx`.
  - 4-bit phase counter.
  - latched data and mask.
- **IDLE**
  - `wr_ready` = 1, `busy` = 0.
  - On `wr_valid` = 1, latch `wr_data`/`wr_mask`, set `idx` = 0, go to SCAN.
- **SCAN**
  - If `mask[idx]` = 1: drive `data_in` = `data[idx]`, load the phase counter, go to SETUP.
  - Else if `idx` = 7: go to DONE.
  - Else: `idx`+1, stay in SCAN.
- **SETUP**
  - Lasts `SETUP_CYC` cycles.
  - `data_in` held, all strobes 0.
  - Then go to PULSE.
- **PULSE**
  - Lasts `HIGH_CYC` cycles with `strobe[7-idx]` = 1 and all other strobes 0.
  - `mirror[idx]` updates to `data[idx]` on entry to PULSE, in the same cycle the strobe rises.
- **HOLD**
  - Lasts 1 cycle.
  - Strobes 0, `data_in` still held.
  - If `idx` = 7, go to DONE; else `idx`+1 and go to SCAN.
- **DONE**
  - Lasts 1 cycle with `done` = 1, `busy` = 1.
  - Then go to IDLE.
- `busy` = 1 in every state except IDLE. `wr_ready` = 1 only in IDLE. Requests are never queued.
- Bits are always processed in ascending order (0..7). At most one strobe is high in any cycle.
- `data_in` is the registered bit value. It keeps its last value in IDLE and only changes on entry to SETUP.
- `strobe`, `data_in`, `done` and `mirror` are driven directly from flops with no combinational logic after the register. This is mandatory because the strobes are clocks.
- Mask = 0x00: no strobe activity, `mirror` unchanged, `done` still pulses.

## Timing

- Handshake: transfer occurs in the cycle where `wr_valid` and `wr_ready` are both 1.
  - `wr_ready` drops in the next cycle.
  - `wr_data`/`wr_mask` are sampled only in the transfer cycle.
- Per selected bit: 1 (SCAN) + `SETUP_CYC` + `HIGH_CYC` + 1 (HOLD) cycles.
- Per unselected bit: 1 cycle (SCAN).
- Total busy cycles = 8 + n·(`SETUP_CYC` + `HIGH_CYC` + 1) + 1, where n is the popcount of the mask.
  - Defaults, mask 0xFF: 33 cycles.
  - Mask 0x00: 9 cycles.
- Minimum `data_in` setup to strobe rise: `SETUP_CYC` cycles. Hold after strobe fall: 1 cycle.
- Back-to-back: a new request can transfer in the first IDLE cycle after DONE.
- Reset, at any time including mid-pulse:
  - Immediately: `strobe` = 0, `data_in` = 0, `done` = 0, `busy` = 0, `mirror` = 0x00, state = IDLE.
  - `wr_ready` = 1 while `rst` is low after release.
  - Any partially written byte is lost. The bank is cleared by the same reset, so `mirror` stays consistent with it.

## Test plan

- **Full write, defaults.** Write 0xA5, mask 0xFF.
  - `strobe[7]`..`strobe[0]` pulse in turn, each for 1 cycle, 4 cycles apart.
  - At each strobe rise, `data_in` equals 1,0,1,0,0,1,0,1 (bits 0..7).
  - `done` at cycle 33; `mirror` = 0xA5; a bank model reads 0xA5.
- **Partial mask.** Start from 0xFF; write 0x00, mask 0x12.
  - Only `strobe[6]` and `strobe[3]` pulse.
  - `mirror` = 0xED; busy for 15 cycles.
- **Empty mask.** Write mask 0x00.
  - No strobe activity; `done` after 9 busy cycles; `mirror` unchanged.
- **Parameters.** `SETUP_CYC` = 3, `HIGH_CYC` = 2, mask 0x01.
  - `data_in` is stable 3 cycles before `strobe[7]` rises.
  - `strobe[7]` is high for exactly 2 cycles.
  - Busy for 15 cycles.
- **Handshake and back-to-back.**
  - With `wr_valid` held high, the request is accepted only when `wr_ready` = 1.
  - The second write starts on the cycle after `done`.
  - Assert at every cycle: `$onehot0(strobe)`.
- **Reset mid-operation.** Assert `rst` during PULSE of bit 3.
  - `strobe` = 0 with no clock edge needed.
  - All outputs return to reset values; `mirror` = 0x00.
  - The next write completes normally.
